// File: rtl/boot_sequencer.sv
// Boot sequencer: regbus-mapped core bring-up controller; BOOTSEQ_WATCHDOG_EN adds the CYCLES/TIMEOUT watchdog.
// Register reads have one-cycle latency; no backpressure, every regbus strobe is accepted in the cycle it arrives.
module boot_sequencer #(
  parameter logic [15:0] BASE_ADDR      = 16'h1000,
  parameter int unsigned RST_CYCLES     = 16,
  parameter logic [31:0] DRAMBASE_RESET = 32'h2000_0000,
  parameter logic [31:0] ENTRYPC_RESET  = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  output logic        core_rst,
  output logic [31:0] dram_base,
  output logic [31:0] entry_pc,
  input  logic        tohost_valid,
  input  logic [31:0] tohost_data,
  output logic        done_irq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TMO  = 3'd4
  } state_t;

  localparam logic [15:0] A_STATUS   = BASE_ADDR + 16'h0000;
  localparam logic [15:0] A_CTRL     = BASE_ADDR + 16'h0004;
  localparam logic [15:0] A_DRAMBASE = BASE_ADDR + 16'h0008;
  localparam logic [15:0] A_ENTRYPC  = BASE_ADDR + 16'h000C;
  localparam logic [15:0] A_TOHOST   = BASE_ADDR + 16'h0010;
  localparam logic [15:0] A_CYCLES   = BASE_ADDR + 16'h0014;
  localparam logic [15:0] A_TIMEOUT  = BASE_ADDR + 16'h0018;
  localparam logic [15:0] RST_LOAD   = 16'(RST_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] rst_cnt;
  logic        ctrl_hold;
  logic [31:0] drambase_reg, entrypc_reg, tohost_reg;
  logic        done_flag, pass_flag, timeout_flag;
  logic        hold_eff, start, term, wdog_hit;
  logic        enter_hold, fin_done, fin_tmo;
  logic        wr_ctrl;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // HOLD_RESET takes its post-write value in the same cycle, so 0x3 holds and 0x2 starts.
  assign wr_ctrl  = WREN && (WRADDR == A_CTRL) && BYTEEN[0];
  assign hold_eff = wr_ctrl ? WDATA[0] : ctrl_hold;
  assign start    = wr_ctrl && WDATA[1] && !hold_eff;
  assign term     = tohost_valid && tohost_data[0];
  assign core_rst = (state != RUN);

`ifdef BOOTSEQ_WATCHDOG_EN
  logic [31:0] cycles, timeout_reg;
  assign wdog_hit = (timeout_reg != 32'd0) && (cycles == timeout_reg - 32'd1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cycles      <= 32'd0;
      timeout_reg <= 32'd5_000_000;
    end else begin
      if (enter_hold) cycles <= 32'd0;
      else if (state == RUN && state_nxt == RUN) cycles <= cycles + 32'd1;
      if (WREN && WRADDR == A_TIMEOUT) timeout_reg <= merge(timeout_reg, WDATA, BYTEEN);
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    enter_hold = 1'b0;
    fin_done   = 1'b0;
    fin_tmo    = 1'b0;
    if (hold_eff) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, TMO: if (start) begin
          state_nxt  = HOLD;
          enter_hold = 1'b1;
        end
        HOLD: if (rst_cnt == 16'd0) state_nxt = RUN;
        RUN: begin
          // A terminating tohost beats the watchdog in the same cycle.
          if (term) begin
            state_nxt = DONE;
            fin_done  = 1'b1;
          end else if (wdog_hit) begin
            state_nxt = TMO;
            fin_tmo   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (RDADDR)
      A_STATUS:   rd_mux = {21'd0, state, 3'd0, timeout_flag, pass_flag, done_flag,
                            (state == RUN), core_rst};
      A_CTRL:     rd_mux = {31'd0, ctrl_hold};
      A_DRAMBASE: rd_mux = drambase_reg;
      A_ENTRYPC:  rd_mux = entrypc_reg;
      A_TOHOST:   rd_mux = tohost_reg;
`ifdef BOOTSEQ_WATCHDOG_EN
      A_CYCLES:   rd_mux = cycles;
      A_TIMEOUT:  rd_mux = timeout_reg;
`endif
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      rst_cnt      <= 16'd0;
      ctrl_hold    <= 1'b0;
      drambase_reg <= DRAMBASE_RESET;
      entrypc_reg  <= ENTRYPC_RESET;
      tohost_reg   <= 32'd0;
      done_flag    <= 1'b0;
      pass_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      dram_base    <= DRAMBASE_RESET;
      entry_pc     <= ENTRYPC_RESET;
      done_irq     <= 1'b0;
      RDATA        <= 32'd0;
    end else begin
      state    <= state_nxt;
      done_irq <= fin_done || fin_tmo;
      if (wr_ctrl) ctrl_hold <= WDATA[0];
      if (WREN && WRADDR == A_DRAMBASE) drambase_reg <= merge(drambase_reg, WDATA, BYTEEN);
      if (WREN && WRADDR == A_ENTRYPC)  entrypc_reg  <= merge(entrypc_reg, WDATA, BYTEEN);
      if (enter_hold) begin
        dram_base    <= drambase_reg;
        entry_pc     <= entrypc_reg;
        done_flag    <= 1'b0;
        pass_flag    <= 1'b0;
        timeout_flag <= 1'b0;
        rst_cnt      <= RST_LOAD;
      end else if (state == HOLD && rst_cnt != 16'd0) begin
        rst_cnt <= rst_cnt - 16'd1;
      end
      if (fin_done) begin
        tohost_reg <= tohost_data;
        done_flag  <= 1'b1;
        pass_flag  <= (tohost_data == 32'd1);
      end
      if (fin_tmo) begin
        done_flag    <= 1'b1;
        pass_flag    <= 1'b0;
        timeout_flag <= 1'b1;
      end
      if (RDEN) RDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: register reads are scoreboarded through a queue of expected values.
module tb_boot_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic        WREN, RDEN;
  logic [31:0] WDATA, RDATA;
  logic        core_rst, done_irq;
  logic [31:0] dram_base, entry_pc;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [15:0] B = 16'h1000;

  boot_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN),
    .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA), .core_rst(core_rst),
    .dram_base(dram_base), .entry_pc(entry_pc), .tohost_valid(tohost_valid),
    .tohost_data(tohost_data), .done_irq(done_irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
    cyc();
    WREN = 1'b0;
  endtask

  task automatic pop_chk();
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, RDATA, e);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e); tag_q.push_back(tag);
    RDADDR = a; RDEN = 1'b1;
    cyc();
    RDEN = 1'b0;
    pop_chk();
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (core_rst && n < 50) begin cyc(); n++; end
    chk(tag, {31'd0, core_rst}, 32'd0);
  endtask

  task automatic tohost(input logic [31:0] d);
    tohost_valid = 1'b1; tohost_data = d;
    cyc();
    tohost_valid = 1'b0; tohost_data = 32'd0;
  endtask

  initial begin
    int cnt;
    ARESET = 1'b1; WRADDR = '0; RDADDR = '0; BYTEEN = '0; WREN = 1'b0; RDEN = 1'b0;
    WDATA = '0; tohost_valid = 1'b0; tohost_data = '0;
    cyc(); cyc();
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_irq", {31'd0, done_irq}, 32'd0);
    chk("rst_dram_base", dram_base, 32'h2000_0000);
    chk("rst_entry_pc", entry_pc, 32'd0);
    ARESET = 1'b0;
    rd(B + 16'h00, 32'h0000_0001, "status_reset");
    rd(B + 16'h08, 32'h2000_0000, "drambase_reset");
    rd(B + 16'h04, 32'h0, "ctrl_reset");

    // Byte enables, and register-only update of DRAMBASE
    wr(B + 16'h08, 32'hAABB_CCDD, 4'b0101);
    rd(B + 16'h08, 32'h20BB_00DD, "drambase_byteen");
    chk("dram_base_not_latched", dram_base, 32'h2000_0000);

    // Same-cycle write and read return the pre-write value
    exp_q.push_back(32'h20BB_00DD); tag_q.push_back("rd_during_wr");
    WRADDR = B + 16'h08; WDATA = 32'h2000_0000; BYTEEN = 4'hF; WREN = 1'b1;
    RDADDR = B + 16'h08; RDEN = 1'b1;
    cyc();
    WREN = 1'b0; RDEN = 1'b0;
    pop_chk();
    rd(B + 16'h08, 32'h2000_0000, "drambase_after_wr");

    // First run: reset held for exactly RST_CYCLES cycles
    wr(B + 16'h0C, 32'h100);
    wr(B + 16'h04, 32'h2);
    cnt = 0;
    while (core_rst && cnt < 40) begin cnt++; cyc(); end
    chk("hold_cycles", cnt, 32'd16);
    chk("entry_pc_run1", entry_pc, 32'h100);
    chk("dram_base_run1", dram_base, 32'h2000_0000);
    rd(B + 16'h00, 32'h0000_0202, "status_run");
    rd(B + 16'h04, 32'h0, "ctrl_start_reads0");

    wr(B + 16'h0C, 32'h200);
    chk("entry_pc_held", entry_pc, 32'h100);
    rd(B + 16'h0C, 32'h200, "entrypc_reg");
    wr(B + 16'h04, 32'h2);
    chk("start_in_run_ignored", {31'd0, core_rst}, 32'd0);

    tohost(32'h4);
    chk("tohost_even_irq", {31'd0, done_irq}, 32'd0);
    chk("tohost_even_running", {31'd0, core_rst}, 32'd0);
    tohost(32'h1);
    chk("pass_irq", {31'd0, done_irq}, 32'd1);
    chk("pass_core_rst", {31'd0, core_rst}, 32'd1);
    cyc();
    chk("pass_irq_pulse", {31'd0, done_irq}, 32'd0);
    rd(B + 16'h00, 32'h0000_030D, "status_pass");
    rd(B + 16'h10, 32'h1, "tohost_pass");

    // Rerun picks up the new ENTRYPC and clears status
    wr(B + 16'h04, 32'h2);
    chk("entry_pc_run2", entry_pc, 32'h200);
    rd(B + 16'h00, 32'h0000_0101, "status_hold");
    wait_run("run2_release");
    tohost(32'h2A);
    chk("tohost_2a_ignored", {31'd0, core_rst}, 32'd0);
    tohost(32'h2B);
    chk("fail_irq", {31'd0, done_irq}, 32'd1);
    cyc();
    chk("fail_irq_pulse", {31'd0, done_irq}, 32'd0);
    rd(B + 16'h00, 32'h0000_0305, "status_fail");
    rd(B + 16'h10, 32'h2B, "tohost_fail");

    // HOLD_RESET aborts a run, blocks START, and 0x2 releases and starts
    wr(B + 16'h04, 32'h2);
    wait_run("run3_release");
    wr(B + 16'h04, 32'h1);
    chk("hold_core_rst", {31'd0, core_rst}, 32'd1);
    chk("hold_no_irq", {31'd0, done_irq}, 32'd0);
    rd(B + 16'h00, 32'h0000_0001, "status_hold_idle");
    rd(B + 16'h04, 32'h1, "ctrl_hold_level");
    wr(B + 16'h04, 32'h3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin if (!core_rst) cnt++; cyc(); end
    chk("hold_wins_over_start", cnt, 32'd0);
    rd(B + 16'h00, 32'h0000_0001, "status_still_idle");
    wr(B + 16'h04, 32'h2);
    rd(B + 16'h00, 32'h0000_0101, "status_release_start");
    wait_run("run4_release");

    // Synchronous reset mid-run
    ARESET = 1'b1;
    cyc();
    ARESET = 1'b0;
    chk("arst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("arst_entry_pc", entry_pc, 32'd0);
    chk("arst_rdata", RDATA, 32'd0);
    rd(B + 16'h00, 32'h0000_0001, "status_after_arst");
    rd(B + 16'h0C, 32'h0, "entrypc_after_arst");

    rd(B + 16'h1C, 32'h0, "unmapped_1c");
    rd(16'h0008, 32'h0, "outside_window");

`ifdef BOOTSEQ_WATCHDOG_EN
    rd(B + 16'h18, 32'd5_000_000, "timeout_reset");
    wr(B + 16'h18, 32'd100);
    rd(B + 16'h18, 32'd100, "timeout_wr");
    wr(B + 16'h04, 32'h2);
    wait_run("wdog_release");
    begin
      int run_cnt = 0;
      int irq_cnt = 0;
      for (int i = 0; i < 300; i++) begin
        if (!core_rst) run_cnt++;
        cyc();
        if (done_irq) irq_cnt++;
      end
      chk("wdog_run_cycles", run_cnt, 32'd100);
      chk("wdog_irq_count", irq_cnt, 32'd1);
    end
    rd(B + 16'h00, 32'h0000_0415, "status_tmo");
    rd(B + 16'h14, 32'd99, "cycles_tmo");
`else
    wr(B + 16'h18, 32'd100);
    rd(B + 16'h18, 32'h0, "timeout_absent");
    rd(B + 16'h14, 32'h0, "cycles_absent");
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
